// File: rtl/cond_unit.sv
// Conditional-execution stage: evaluates the condition field against the architectural
// flags and emits gated controls through a one-deep register slice. Optional sticky Q: COND_STICKY_Q_EN.
module cond_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  cond_i,
  input  logic [1:0]  flagw_i,
  input  logic [3:0]  alu_flags_i,
  input  logic        pcs_i,
  input  logic        regw_i,
  input  logic        memw_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        pcsrc_o,
  output logic        regwrite_o,
  output logic        memwrite_o,
  output logic        condex_o,
  output logic [3:0]  flags_o,
`ifdef COND_STICKY_Q_EN
  output logic [15:0] skip_cnt_o,
  input  logic        q_clr_i,
  output logic        q_flag_o
`else
  output logic [15:0] skip_cnt_o
`endif
);

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_UN = 4'hF
  } cond_code_e;

  logic [3:0]  flags_q, flags_d;
  logic        valid_q, valid_d;
  logic        pcsrc_q, pcsrc_d;
  logic        regwrite_q, regwrite_d;
  logic        memwrite_q, memwrite_d;
  logic        condex_q, condex_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic        accept;
  logic        condex;
  logic        flag_n, flag_z, flag_c, flag_v;

  // Evaluate against the registered flags only; no bypass from the ALU.
  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  always_comb begin
    condex = 1'b1;
    case (cond_code_e'(cond_i))
      CC_EQ:   condex = flag_z;
      CC_NE:   condex = !flag_z;
      CC_CS:   condex = flag_c;
      CC_CC:   condex = !flag_c;
      CC_MI:   condex = flag_n;
      CC_PL:   condex = !flag_n;
      CC_VS:   condex = flag_v;
      CC_VC:   condex = !flag_v;
      CC_HI:   condex = flag_c && !flag_z;
      CC_LS:   condex = !flag_c || flag_z;
      CC_GE:   condex = (flag_n == flag_v);
      CC_LT:   condex = (flag_n != flag_v);
      CC_GT:   condex = !flag_z && (flag_n == flag_v);
      CC_LE:   condex = flag_z || (flag_n != flag_v);
      CC_AL:   condex = 1'b1;
      default: condex = 1'b1;
    endcase
  end

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o && !flush_i;

  always_comb begin
    flags_d    = flags_q;
    valid_d    = valid_q;
    pcsrc_d    = pcsrc_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    condex_d   = condex_q;
    skip_cnt_d = skip_cnt_q;

    if (flush_i || (!accept && ready_i)) begin
      // Squash or drain: the slot empties and carries no side effects.
      valid_d    = 1'b0;
      pcsrc_d    = 1'b0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      condex_d   = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      pcsrc_d    = pcs_i & condex;
      regwrite_d = regw_i & condex;
      memwrite_d = memw_i & condex;
      condex_d   = condex;
    end

    if (accept && condex) begin
      if (flagw_i[1]) flags_d[3:2] = alu_flags_i[3:2];
      if (flagw_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    end

    if (accept && !condex && (skip_cnt_q != 16'hFFFF)) begin
      skip_cnt_d = skip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= 4'h0;
      valid_q    <= 1'b0;
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      condex_q   <= 1'b0;
      skip_cnt_q <= 16'h0000;
    end else begin
      flags_q    <= flags_d;
      valid_q    <= valid_d;
      pcsrc_q    <= pcsrc_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      condex_q   <= condex_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign valid_o    = valid_q;
  assign pcsrc_o    = pcsrc_q;
  assign regwrite_o = regwrite_q;
  assign memwrite_o = memwrite_q;
  assign condex_o   = condex_q;
  assign flags_o    = flags_q;
  assign skip_cnt_o = skip_cnt_q;

`ifdef COND_STICKY_Q_EN
  logic q_flag_q, q_flag_d;

  // A coincident set beats the clear.
  always_comb begin
    q_flag_d = q_flag_q;
    if (accept && condex && flagw_i[0] && alu_flags_i[0]) begin
      q_flag_d = 1'b1;
    end else if (q_clr_i) begin
      q_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_flag_q <= 1'b0;
    end else begin
      q_flag_q <= q_flag_d;
    end
  end

  assign q_flag_o = q_flag_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized traffic against a
// behavioural model; build with COND_STICKY_Q_EN defined to exercise the sticky Q flag.
module tb_cond_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  cond_i = 4'h0;
  logic [1:0]  flagw_i = 2'b00;
  logic [3:0]  alu_flags_i = 4'h0;
  logic        pcs_i = 1'b0, regw_i = 1'b0, memw_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        pcsrc_o, regwrite_o, memwrite_o, condex_o;
  logic [3:0]  flags_o;
  logic [15:0] skip_cnt_o;
`ifdef COND_STICKY_Q_EN
  logic        q_clr_i = 1'b0;
  logic        q_flag_o;
`endif

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  cond_unit dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .cond_i(cond_i), .flagw_i(flagw_i), .alu_flags_i(alu_flags_i),
    .pcs_i(pcs_i), .regw_i(regw_i), .memw_i(memw_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .pcsrc_o(pcsrc_o),
    .regwrite_o(regwrite_o), .memwrite_o(memwrite_o), .condex_o(condex_o),
    .flags_o(flags_o),
`ifdef COND_STICKY_Q_EN
    .skip_cnt_o(skip_cnt_o), .q_clr_i(q_clr_i), .q_flag_o(q_flag_o)
`else
    .skip_cnt_o(skip_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Codes come in complementary pairs: even code tests a predicate, odd code its negation.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  logic [3:0] m_flags;
  logic       m_valid, m_pc, m_rw, m_mw, m_cx;
  int         m_cnt;
  logic       m_ready, m_acc, m_pass;
`ifdef COND_STICKY_Q_EN
  logic       m_q;
`endif

  assign m_ready = !m_valid || ready_i;
  assign m_acc   = valid_i && m_ready && !flush_i;
  assign m_pass  = cond_holds(cond_i, m_flags);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flags <= 4'h0; m_valid <= 1'b0; m_pc <= 1'b0; m_rw <= 1'b0; m_mw <= 1'b0;
      m_cx <= 1'b0; m_cnt <= 0;
`ifdef COND_STICKY_Q_EN
      m_q <= 1'b0;
`endif
    end else begin
      if (m_acc) begin
        m_valid <= 1'b1;
        m_pc <= pcs_i && m_pass; m_rw <= regw_i && m_pass; m_mw <= memw_i && m_pass;
        m_cx <= m_pass;
        if (m_pass) begin
          m_flags <= { flagw_i[1] ? alu_flags_i[3:2] : m_flags[3:2],
                       flagw_i[0] ? alu_flags_i[1:0] : m_flags[1:0] };
        end else if (m_cnt < 65535) begin
          m_cnt <= m_cnt + 1;
        end
      end else if (flush_i || ready_i) begin
        m_valid <= 1'b0; m_pc <= 1'b0; m_rw <= 1'b0; m_mw <= 1'b0;
      end
`ifdef COND_STICKY_Q_EN
      if (m_acc && m_pass && flagw_i[0] && alu_flags_i[0]) m_q <= 1'b1;
      else if (q_clr_i) m_q <= 1'b0;
`endif
    end
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid_o", valid_o, m_valid);
      chk("ready_o", ready_o, m_ready);
      chk("pcsrc_o", pcsrc_o, m_pc);
      chk("regwrite_o", regwrite_o, m_rw);
      chk("memwrite_o", memwrite_o, m_mw);
      if (m_valid) chk("condex_o", condex_o, m_cx);
      chk("flags_o", flags_o, m_flags);
      chk("skip_cnt_o", skip_cnt_o, m_cnt[15:0]);
`ifdef COND_STICKY_Q_EN
      chk("q_flag_o", q_flag_o, m_q);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ctl = {pcs, regw, memw}
  task automatic put(input logic v, input logic [3:0] c, input logic [1:0] fw,
                     input logic [3:0] af, input logic [2:0] ctl, input logic fl, input logic rdy);
    valid_i = v; cond_i = c; flagw_i = fw; alu_flags_i = af;
    {pcs_i, regw_i, memw_i} = ctl; flush_i = fl; ready_i = rdy;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    put(0, 4'h0, 2'b00, 4'h0, 3'b000, 0, 1);
    tick(); tick();
    chk("rst_flags", flags_o, 4'h0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_skip", skip_cnt_o, 16'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Unconditional flag write
    put(1, 4'hE, 2'b11, 4'b0100, 3'b010, 0, 1); tick();
    chk("s1_flags", flags_o, 4'b0100);
    chk("s1_regwrite", regwrite_o, 1'b1);
    chk("s1_valid", valid_o, 1'b1);

    // EQ passes, NE fails
    put(1, 4'h0, 2'b00, 4'h0, 3'b001, 0, 1); tick();
    chk("s2_memw_eq", memwrite_o, 1'b1);
    put(1, 4'h1, 2'b00, 4'h0, 3'b001, 0, 1); tick();
    chk("s2_memw_ne", memwrite_o, 1'b0);
    chk("s2_skip", skip_cnt_o, 16'd1);

    // GT with N=V, then C,V-only flag write
    put(1, 4'hE, 2'b11, 4'b1001, 3'b000, 0, 1); tick();
    chk("s3_pre_flags", flags_o, 4'b1001);
    put(1, 4'hC, 2'b01, 4'b0010, 3'b000, 0, 1); tick();
    chk("s3_condex", condex_o, 1'b1);
    chk("s3_flags", flags_o, 4'b1010);

    // Failing EQ must not write flags
    put(1, 4'h0, 2'b11, 4'b1111, 3'b000, 0, 1); tick();
    chk("s4_flags", flags_o, 4'b1010);
    chk("s4_condex", condex_o, 1'b0);
    chk("s4_skip", skip_cnt_o, 16'd2);

    // Downstream stall for three cycles
    put(1, 4'hE, 2'b11, 4'b0000, 3'b010, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_stall_valid", valid_o, 1'b1);
      chk("s4_stall_condex", condex_o, 1'b0);
      chk("s4_stall_ready", ready_o, 1'b0);
      chk("s4_stall_skip", skip_cnt_o, 16'd2);
      chk("s4_stall_flags", flags_o, 4'b1010);
    end
    put(0, 4'hE, 2'b00, 4'h0, 3'b000, 0, 1); tick();
    chk("s4_drain_valid", valid_o, 1'b0);

    // Flush drops a coincident instruction
    put(1, 4'hE, 2'b11, 4'b0000, 3'b111, 1, 1); tick();
    chk("s5_flush_valid", valid_o, 1'b0);
    chk("s5_flush_flags", flags_o, 4'b1010);
    put(1, 4'hE, 2'b00, 4'h0, 3'b111, 0, 0); tick();
    put(1, 4'h0, 2'b11, 4'h0, 3'b111, 1, 0); tick();
    chk("s5_flush_stalled_valid", valid_o, 1'b0);
    chk("s5_flush_stalled_pcsrc", pcsrc_o, 1'b0);
    chk("s5_flush_skip", skip_cnt_o, 16'd2);

    // Drive the skip counter to saturation
    put(1, 4'h0, 2'b11, 4'h0, 3'b000, 0, 1);
    for (int i = 0; i < 65533; i++) tick();
    chk("s5_skip_full", skip_cnt_o, 16'hFFFF);
    tick();
    chk("s5_skip_sat", skip_cnt_o, 16'hFFFF);

    // Asynchronous reset while a result is held
    put(1, 4'hE, 2'b00, 4'h0, 3'b111, 0, 0); tick();
    chk("rst_mid_pre_valid", valid_o, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", valid_o, 1'b0);
    chk("rst_mid_pcsrc", pcsrc_o, 1'b0);
    chk("rst_mid_flags", flags_o, 4'h0);
    chk("rst_mid_skip", skip_cnt_o, 16'h0);
    chk("rst_mid_ready", ready_o, 1'b1);
    tick();
    chk("rst_hold_valid", valid_o, 1'b0);
    rst_n = 1'b1;
    put(0, 4'h0, 2'b00, 4'h0, 3'b000, 0, 1); tick();

`ifdef COND_STICKY_Q_EN
    put(1, 4'hE, 2'b01, 4'b0001, 3'b000, 0, 1); tick();
    chk("q_set", q_flag_o, 1'b1);
    put(1, 4'hE, 2'b01, 4'b0000, 3'b000, 0, 1); tick();
    chk("q_sticky", q_flag_o, 1'b1);
    put(0, 4'h0, 2'b00, 4'h0, 3'b000, 0, 1); q_clr_i = 1'b1; tick();
    chk("q_clr", q_flag_o, 1'b0);
    put(1, 4'hE, 2'b01, 4'b0001, 3'b000, 0, 1); tick();
    chk("q_set_wins", q_flag_o, 1'b1);
    q_clr_i = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      put($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 4'($urandom),
          3'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7);
`ifdef COND_STICKY_Q_EN
      q_clr_i = $urandom_range(0, 9) == 0;
`endif
      tick();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
